demux2_32_buf: RTL and testbench
================================

// Module: demux2_32_buf
// PURPOSE
//   Fan-out counterpart of the 2:1 result mux. Routes one 32-bit producer stream to one of two
//   consumers (A/B) under a valid/ready handshake. Each output has a one-entry holding register, so
//   a stalled consumer never corrupts in-flight data. Sits between a result source (ALU/load path)
//   and two downstream stages in the RV32I datapath.
// PARAMETERS
//   WIDTH   32   data width of input and both outputs
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_data    in   WIDTH  producer data
//   in_sel     in   1      destination: 0 -> A, 1 -> B
//   in_valid   in   1      producer has data
//   in_ready   out  1      block accepts in_data this cycle
//   a_data     out  WIDTH  output A data (registered)
//   a_valid    out  1      output A holds data
//   a_ready    in   1      consumer A takes data
//   b_data     out  WIDTH  output B data (registered)
//   b_valid    out  1      output B holds data
//   b_ready    in   1      consumer B takes data
// BEHAVIOUR
//   - Reset (async, rst=1): a_valid=b_valid=0, a_data=b_data=0; counters (if enabled) =0. Effective
//     immediately; any held word is discarded. Deassertion sampled on next clk edge.
//   - Per output X: state EMPTY (X_valid=0) / FULL (X_valid=1); X_data is the register contents.
//   - Drain: X_valid && X_ready at edge -> word consumed.
//   - in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready). Combinational on in_sel and
//     the selected side's ready; unselected side has no influence.
//   - Accept: in_valid && in_ready at edge -> selected register loads in_data, X_valid=1 next cycle.
//     Latency accept -> X_valid: 1 cycle. Throughput: 1 word/cycle per side when consumer ready.
//   - Simultaneous drain + accept on same side: register reloads, X_valid stays 1 (no bubble).
//   - Drain on one side + accept on other side in same cycle: both independent.
//   - FULL and X_ready=0: in_ready=0 when selecting X; X_data/X_valid held stable.
//   - Producer rule: in_data/in_sel held stable while in_valid=1 and not accepted; block does not
//     check this. in_valid=0 -> no state change other than drains.
//   - No ordering guarantee between A and B; order within one side preserved (depth 1).
//   - X_data only meaningful while X_valid=1; unchanged after drain until next load.
// CONFIGURATION
//   DEMUX2_32_COUNT_EN defined: adds ports a_count, b_count (out, 16 bits each): number of completed
//     output transfers (X_valid && X_ready) per side, incremented at the edge, wrap 0xFFFF -> 0x0000,
//     cleared by rst. Datapath behaviour identical.
//   Not defined: no counter ports, no counter logic.
// TESTING
//   1. rst=1 mid-transfer with a_valid=1 -> a_valid=0, a_data=0 same cycle, before any clk edge.
//   2. in_sel=0, in_data=0x12345678, in_valid=1, a_ready=1 for 1 cycle -> next cycle a_valid=1,
//      a_data=0x12345678; b_valid stays 0.
//   3. Stream 0x1,0x2,0x3 to B with b_ready=1 every cycle -> in_ready=1 every cycle, b_data
//      0x1,0x2,0x3 on consecutive cycles, no bubble.
//   4. A full (0xAAAA0000), a_ready=0, in_sel=0 -> in_ready=0, a_data held; switch in_sel=1 with
//      0xBBBB0000 -> in_ready=1, b_data=0xBBBB0000 next cycle, a_data still 0xAAAA0000.
//   5. A full, a_ready=1 and new word 0xC0DE0001 to A same cycle -> a_valid stays 1,
//      a_data=0xC0DE0001.
//   6. DEMUX2_32_COUNT_EN: 65537 transfers on A -> a_count=1 (wrapped), b_count=0; rst -> both 0.

Source files
------------

// File: rtl/demux2_32_buf.sv
// 1-to-2 stream demux with a one-entry holding register per output (valid/ready on all sides).
// Optional per-side transfer counters when DEMUX2_32_COUNT_EN is defined.
module demux2_32_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX2_32_COUNT_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);

    logic a_room;
    logic b_room;
    logic a_load;
    logic b_load;
    logic a_drain;
    logic b_drain;

    // A side can take a word when empty or when its current word leaves this edge.
    always_comb begin
        a_room   = ~a_valid | a_ready;
        b_room   = ~b_valid | b_ready;
        in_ready = in_sel ? b_room : a_room;
        a_load   = in_valid & in_ready & ~in_sel;
        b_load   = in_valid & in_ready & in_sel;
        a_drain  = a_valid & a_ready;
        b_drain  = b_valid & b_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data  <= '0;
            a_valid <= 1'b0;
        end else if (a_load) begin
            a_data  <= in_data;
            a_valid <= 1'b1;
        end else if (a_drain) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_data  <= '0;
            b_valid <= 1'b0;
        end else if (b_load) begin
            b_data  <= in_data;
            b_valid <= 1'b1;
        end else if (b_drain) begin
            b_valid <= 1'b0;
        end
    end

`ifdef DEMUX2_32_COUNT_EN
    // Completed output transfers; wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_drain) a_count <= a_count + 16'd1;
            if (b_drain) b_count <= b_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux2_32_buf.sv
// Randomized and directed bench for demux2_32_buf against a queue-based model of the two outputs.
module tb_demux2_32_buf;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX2_32_COUNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    demux2_32_buf #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX2_32_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic model_in_ready();
        if (in_sel) return (qb.size() == 0) || b_ready;
        return (qa.size() == 0) || a_ready;
    endfunction

    // Model: each side is a queue of at most one word; consumer pops, producer pushes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            logic acc;
            acc = in_valid && model_in_ready();
            if (qa.size() != 0 && a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && b_ready) void'(qb.pop_front());
            if (acc) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
            if (qa.size() != 0) check("m_a_data", a_data, qa[0]);
            check("m_b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
            if (qb.size() != 0) check("m_b_data", b_data, qb[0]);
            check("m_in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pending;
        rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        #1;
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_a_data", a_data, 32'd0);
        check("rst_b_data", b_data, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Single word to A
        in_sel = 1'b0; in_data = 32'h12345678; in_valid = 1'b1; a_ready = 1'b1;
        step();
        in_valid = 1'b0; a_ready = 1'b0;
        #1;
        check("t2_a_valid", {31'd0, a_valid}, 32'd1);
        check("t2_a_data", a_data, 32'h12345678);
        check("t2_b_valid", {31'd0, b_valid}, 32'd0);

        // Asynchronous reset mid-cycle while A is full
        #1 rst = 1'b1;
        #1;
        check("t1_a_valid", {31'd0, a_valid}, 32'd0);
        check("t1_a_data", a_data, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Back-to-back stream to B
        in_sel = 1'b1; in_valid = 1'b1; b_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 32'(i);
            #1;
            check("t3_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            check("t3_b_valid", {31'd0, b_valid}, 32'd1);
            check("t3_b_data", b_data, 32'(i));
        end
        in_valid = 1'b0;
        step();

        // A full and stalled; B still accepts
        in_sel = 1'b0; in_data = 32'hAAAA0000; in_valid = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
        step();
        #1;
        check("t4_in_ready_a", {31'd0, in_ready}, 32'd0);
        step();
        check("t4_a_held", a_data, 32'hAAAA0000);
        in_sel = 1'b1; in_data = 32'hBBBB0000;
        #1;
        check("t4_in_ready_b", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("t4_b_data", b_data, 32'hBBBB0000);
        check("t4_a_data", a_data, 32'hAAAA0000);
        check("t4_a_valid", {31'd0, a_valid}, 32'd1);

        // Drain and reload A in the same cycle
        in_sel = 1'b0; in_data = 32'hC0DE0001; in_valid = 1'b1; a_ready = 1'b1;
        step();
        in_valid = 1'b0; a_ready = 1'b0;
        #1;
        check("t5_a_valid", {31'd0, a_valid}, 32'd1);
        check("t5_a_data", a_data, 32'hC0DE0001);
        b_ready = 1'b1; a_ready = 1'b1;
        step();

        // Random traffic; producer holds its word until accepted
        pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 2) != 0);
            if (!pending) begin
                in_valid = ($urandom_range(0, 4) != 0);
                in_sel   = $urandom_range(0, 1);
                in_data  = $urandom;
            end
            #1;
            pending = in_valid && !in_ready;
            step();
        end
        in_valid = 1'b0;

`ifdef DEMUX2_32_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        for (int n = 0; n < 65537; n++) begin
            in_data = 32'(n);
            step();
        end
        in_valid = 1'b0;
        step();
        check("t6_a_count", {16'd0, a_count}, 32'd1);
        check("t6_b_count", {16'd0, b_count}, 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_a_count", {16'd0, a_count}, 32'd0);
        check("t6_rst_b_count", {16'd0, b_count}, 32'd0);
        step();
        rst = 1'b0;
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
